bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
- Generates 8085 machine-cycle bus timing: T-state sequencing, status (S0/S1/IOMn), ALE, RDn/WRn, the multiplexed AD7..0 drive and the high address byte.
- Sits directly upstream of the CPU top. It replaces the bench-driven S0/S1/IOMn/RDn/WRn/ALE and dbus_to_instr_reg inputs.
- Accepts one machine-cycle request at a time from the microcode sequencer and returns read data with a valid pulse.

Parameters:
- MAX_WAIT, 15: maximum consecutive TW states before forced completion; 0 = unlimited.
- ADDR_W, 16: address width (fixed at 16; the parameter is present for the package constant).

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous active-low reset
- mc_start  in  1  request a machine cycle; sampled in IDLE or the final T-state only
- mc_type  in  3  0=opcode fetch, 1=mem read, 2=mem write, 3=IO read, 4=IO write; 5..7 invalid
- mc_addr  in  16  cycle address, captured at accept
- mc_wdata  in  8  write data, captured at accept
- ready  in  1  external READY, sampled at the posedge that ends T2/TW
- ad_in  in  8  AD7..0 input (from the laddress_data pad)
- ad_out  out  8  AD7..0 drive value
- ad_oe  out  1  AD7..0 output enable
- haddress  out  8  A15..8
- S0, S1, IOMn, RDn, WRn, ALE  out  1 each  8085 bus control
- dbus_to_instr_reg  out  1  instruction-register load strobe
- rdata  out  8  captured read data
- rdata_valid  out  1  one-cycle pulse
- busy  out  1  high from T1 through the final T-state
- bus_err  out  1  one-cycle pulse on wait timeout
- tstate  out  3  current state, for debug

Behaviour:
- Reset (async, rst=0): state IDLE; RDn=WRn=1; ALE=0; S0=S1=0; IOMn=0; ad_oe=0; ad_out=0; haddress=0; rdata=0; all pulses 0; wait counter 0.
- States: IDLE, T1, T2, TW, T3, T4. All outputs are registered.
- Accept:
  - IDLE & mc_start & valid type -> T1; capture type, addr and wdata.
  - An invalid type is ignored and the block stays in IDLE.
- T1:
  - ALE=1, ad_oe=1, ad_out=addr[7:0].
  - haddress=addr[15:8]; for IO cycles haddress=addr[7:0] (port replicated on both halves).
  - Status S1S0: fetch=11, read=10, write=01. IOMn=1 for IO cycles, else 0.
  - Status and haddress are held until the next T1 or IDLE.
- T2:
  - Read types: RDn=0, ad_oe=0.
  - Write types: WRn=0, ad_oe=1, ad_out=wdata.
  - ready=1 -> T3; ready=0 -> TW.
- TW: strobes held. ready=1 -> T3. Otherwise increment the wait counter; when the counter reaches MAX_WAIT (MAX_WAIT≠0), pulse bus_err and go to T3.
- T3:
  - Strobes held.
  - For opcode fetch, dbus_to_instr_reg=1 for exactly this state.
  - At the posedge leaving T3, read types capture rdata<=ad_in and pulse rdata_valid in the next state.
  - RDn/WRn return to 1 at that edge.
  - Fetch -> T4; others -> final.
- T4 (fetch only): ad_oe=0, no strobes; final.
- Final state (T3 non-fetch, T4 fetch):
  - busy still 1.
  - mc_start with a valid type -> T1 directly (back-to-back, no idle gap); otherwise -> IDLE.
- IDLE: S0=S1=0, IOMn held, strobes inactive, ad_oe=0, busy=0.
- Ignored requests: mc_start outside IDLE/final is ignored and does not queue.
- Wait counter: cleared at every T1.
- Reset mid-cycle: immediate return to reset values. An in-flight read produces no rdata_valid.
- Strobe exclusivity: RDn and WRn are never both 0. ALE is never 1 while RDn or WRn is 0.

Decomposition:
- Package bus_pkg: mcycle_t enum (OF, MR, MW, IOR, IOW), tstate_t enum, status encoding constants (ST_FETCH=2'b11, ST_READ=2'b10, ST_WRITE=2'b01, ST_HALT=2'b00), ADDR_W.
- Single module. The wait counter is inline; no sub-module is warranted.

Test Plan:
- Fetch at 0x1234, ready=1, ad_in=0x43 in T3:
  - T1: ALE=1, ad_out=0x34, haddress=0x12, S1S0=11.
  - T2–T3: RDn=0. T3: dbus_to_instr_reg=1.
  - rdata=0x43 with rdata_valid the cycle after T3. T4 present. 4 cycles total.
- Mem write 0x8001 with data 0xA5:
  - S1S0=01, IOMn=0.
  - T2–T3: WRn=0 and ad_out=0xA5.
  - 3 cycles, no rdata_valid.
- IO read port 0x2F:
  - IOMn=1, haddress=0x2F, ad_out=0x2F in T1.
  - Read with ad_in=0x5A gives rdata=0x5A.
- Mem read with ready low 3 cycles:
  - Exactly 3 TW states, RDn held low, completes with bus_err=0.
  - With MAX_WAIT=2 and ready stuck low: 2 TW, bus_err pulses, cycle completes.
- Back-to-back: fetch then mem read with mc_start held at T4:
  - The T1 of the second cycle immediately follows T4; busy never drops.
- Reset mid-cycle:
  - rst=0 during T2 of a read: RDn=1, ALE=0, ad_oe=0 asynchronously, no rdata_valid.
  - After release, the block sits in IDLE.
  - mc_type=6 in IDLE: no bus activity.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the 8085 machine-cycle bus controller
package bus_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        OF  = 3'd0,
        MR  = 3'd1,
        MW  = 3'd2,
        IOR = 3'd3,
        IOW = 3'd4
    } mcycle_t;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_TW   = 3'd3,
        TS_T3   = 3'd4,
        TS_T4   = 3'd5
    } tstate_t;

    localparam logic [1:0] ST_FETCH = 2'b11;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b00;

    function automatic logic type_valid(input logic [2:0] t);
        return t <= 3'd4;
    endfunction

    function automatic logic is_read(input mcycle_t t);
        return (t == OF) || (t == MR) || (t == IOR);
    endfunction

    function automatic logic is_io(input mcycle_t t);
        return (t == IOR) || (t == IOW);
    endfunction

    function automatic logic [1:0] status_of(input mcycle_t t);
        if (t == OF)
            return ST_FETCH;
        else if (is_read(t))
            return ST_READ;
        else
            return ST_WRITE;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// rtl/bus_cycle_ctrl_if.sv - request/response and 8085 bus signals of the cycle controller
interface bus_cycle_ctrl_if;
    import bus_pkg::*;

    logic              mc_start;
    logic [2:0]        mc_type;
    logic [ADDR_W-1:0] mc_addr;
    logic [7:0]        mc_wdata;
    logic              ready;
    logic [7:0]        ad_in;
    logic [7:0]        ad_out;
    logic              ad_oe;
    logic [7:0]        haddress;
    logic              S0;
    logic              S1;
    logic              IOMn;
    logic              RDn;
    logic              WRn;
    logic              ALE;
    logic              dbus_to_instr_reg;
    logic [7:0]        rdata;
    logic              rdata_valid;
    logic              busy;
    logic              bus_err;
    logic [2:0]        tstate;

    // slave: the controller itself; master: the requester driving it
    modport slave (
        input  mc_start, mc_type, mc_addr, mc_wdata, ready, ad_in,
        output ad_out, ad_oe, haddress, S0, S1, IOMn, RDn, WRn, ALE,
               dbus_to_instr_reg, rdata, rdata_valid, busy, bus_err, tstate
    );

    modport master (
        output mc_start, mc_type, mc_addr, mc_wdata, ready, ad_in,
        input  ad_out, ad_oe, haddress, S0, S1, IOMn, RDn, WRn, ALE,
               dbus_to_instr_reg, rdata, rdata_valid, busy, bus_err, tstate
    );

endinterface

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 8085 machine-cycle T-state sequencer with registered bus outputs
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    bus_cycle_ctrl_if.slave  bus
);

    tstate_t     state;
    mcycle_t     cyc_type;
    logic [7:0]  cyc_wdata;
    logic [15:0] wait_cnt;
    logic        req_ok;
    logic        finishing;
    mcycle_t     req_type;

    assign req_type  = mcycle_t'(bus.mc_type);
    assign req_ok    = bus.mc_start && type_valid(bus.mc_type);
    assign finishing = ((state == TS_T3) && (cyc_type != OF)) || (state == TS_T4);
    assign bus.tstate = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= TS_IDLE;
            cyc_type              <= OF;
            cyc_wdata             <= 8'h00;
            wait_cnt              <= 16'd0;
            bus.ad_out            <= 8'h00;
            bus.ad_oe             <= 1'b0;
            bus.haddress          <= 8'h00;
            bus.S0                <= 1'b0;
            bus.S1                <= 1'b0;
            bus.IOMn              <= 1'b0;
            bus.RDn               <= 1'b1;
            bus.WRn               <= 1'b1;
            bus.ALE               <= 1'b0;
            bus.dbus_to_instr_reg <= 1'b0;
            bus.rdata             <= 8'h00;
            bus.rdata_valid       <= 1'b0;
            bus.busy              <= 1'b0;
            bus.bus_err           <= 1'b0;
        end else begin
            bus.ALE               <= 1'b0;
            bus.dbus_to_instr_reg <= 1'b0;
            bus.rdata_valid       <= 1'b0;
            bus.bus_err           <= 1'b0;

            case (state)
                TS_T1: begin
                    state <= TS_T2;
                    if (is_read(cyc_type)) begin
                        bus.RDn   <= 1'b0;
                        bus.ad_oe <= 1'b0;
                    end else begin
                        bus.WRn    <= 1'b0;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= cyc_wdata;
                    end
                end
                TS_T2: begin
                    if (bus.ready) begin
                        state                 <= TS_T3;
                        bus.dbus_to_instr_reg <= (cyc_type == OF);
                    end else begin
                        state <= TS_TW;
                    end
                end
                TS_TW: begin
                    if (bus.ready) begin
                        state                 <= TS_T3;
                        bus.dbus_to_instr_reg <= (cyc_type == OF);
                    end else if ((MAX_WAIT != 0) && (int'(wait_cnt) + 1 == MAX_WAIT)) begin
                        state                 <= TS_T3;
                        bus.bus_err           <= 1'b1;
                        bus.dbus_to_instr_reg <= (cyc_type == OF);
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                TS_T3: begin
                    bus.RDn <= 1'b1;
                    bus.WRn <= 1'b1;
                    if (is_read(cyc_type)) begin
                        bus.rdata       <= bus.ad_in;
                        bus.rdata_valid <= 1'b1;
                    end
                    if (cyc_type == OF) begin
                        state     <= TS_T4;
                        bus.ad_oe <= 1'b0;
                    end
                end
                default: ;
            endcase

            // IDLE and the final T-state share the accept path so back-to-back cycles need no gap
            if ((state == TS_IDLE) || finishing) begin
                if (req_ok) begin
                    state        <= TS_T1;
                    cyc_type     <= req_type;
                    cyc_wdata    <= bus.mc_wdata;
                    wait_cnt     <= 16'd0;
                    bus.ALE      <= 1'b1;
                    bus.ad_oe    <= 1'b1;
                    bus.ad_out   <= bus.mc_addr[7:0];
                    bus.haddress <= is_io(req_type) ? bus.mc_addr[7:0] : bus.mc_addr[15:8];
                    {bus.S1, bus.S0} <= status_of(req_type);
                    bus.IOMn     <= is_io(req_type);
                    bus.busy     <= 1'b1;
                end else begin
                    state     <= TS_IDLE;
                    bus.S0    <= 1'b0;
                    bus.S1    <= 1'b0;
                    bus.ad_oe <= 1'b0;
                    bus.busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - scoreboard bench for bus_cycle_ctrl machine-cycle timing
module tb_bus_cycle_ctrl;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e0;
    logic [7:0] e1;

    bus_cycle_ctrl_if b0();
    bus_cycle_ctrl_if b1();

    bus_cycle_ctrl #(.MAX_WAIT(15)) u_dut  (.clk(clk), .rst(rst_n), .bus(b0));
    bus_cycle_ctrl #(.MAX_WAIT(2))  u_dut2 (.clk(clk), .rst(rst_n), .bus(b1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int dut, input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
        if (dut == 0) begin
            b0.mc_start = 1'b1; b0.mc_type = t; b0.mc_addr = a; b0.mc_wdata = d;
        end else begin
            b1.mc_start = 1'b1; b1.mc_type = t; b1.mc_addr = a; b1.mc_wdata = d;
        end
    endtask

    // Monitor: pops expected read data whenever a DUT presents rdata_valid
    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.rdata_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_unexpected_valid: got rdata_valid with rdata=%02h, required none", b0.rdata);
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0_rdata", {24'h0, b0.rdata}, {24'h0, e0});
                end
            end
            if (b1.rdata_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_unexpected_valid: got rdata_valid with rdata=%02h, required none", b1.rdata);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1_rdata", {24'h0, b1.rdata}, {24'h0, e1});
                end
            end
            chk("strobe_exclusive", {31'h0, (!b0.RDn && !b0.WRn) || (b0.ALE && (!b0.RDn || !b0.WRn))}, 32'h0);
        end
    end

    initial begin
        b0.mc_start = 0; b0.mc_type = 0; b0.mc_addr = 0; b0.mc_wdata = 0; b0.ready = 1; b0.ad_in = 0;
        b1.mc_start = 0; b1.mc_type = 0; b1.mc_addr = 0; b1.mc_wdata = 0; b1.ready = 1; b1.ad_in = 0;
        step(); step();
        chk("rst_RDn", b0.RDn, 1); chk("rst_WRn", b0.WRn, 1); chk("rst_ALE", b0.ALE, 0);
        chk("rst_tstate", b0.tstate, 0); chk("rst_rdata", b0.rdata, 0); chk("rst_haddr", b0.haddress, 0);
        chk("rst_busy", b0.busy, 0); chk("rst_ad_oe", b0.ad_oe, 0); chk("rst_status", {b0.S1, b0.S0}, 0);
        rst_n = 1'b1;
        step();

        // Opcode fetch at 0x1234
        issue(0, 3'd0, 16'h1234, 8'h00); b0.ready = 1; b0.ad_in = 8'h43; q0.push_back(8'h43);
        step(); b0.mc_start = 0;
        chk("of_t1_state", b0.tstate, 1); chk("of_t1_ALE", b0.ALE, 1); chk("of_t1_ad_out", b0.ad_out, 8'h34);
        chk("of_t1_haddr", b0.haddress, 8'h12); chk("of_t1_status", {b0.S1, b0.S0}, 2'b11);
        chk("of_t1_IOMn", b0.IOMn, 0); chk("of_t1_ad_oe", b0.ad_oe, 1); chk("of_t1_busy", b0.busy, 1);
        step();
        chk("of_t2_state", b0.tstate, 2); chk("of_t2_RDn", b0.RDn, 0); chk("of_t2_ALE", b0.ALE, 0); chk("of_t2_ad_oe", b0.ad_oe, 0);
        step();
        chk("of_t3_state", b0.tstate, 4); chk("of_t3_RDn", b0.RDn, 0); chk("of_t3_instr", b0.dbus_to_instr_reg, 1);
        step();
        chk("of_t4_state", b0.tstate, 5); chk("of_t4_RDn", b0.RDn, 1); chk("of_t4_valid", b0.rdata_valid, 1);
        chk("of_t4_rdata", b0.rdata, 8'h43); chk("of_t4_instr", b0.dbus_to_instr_reg, 0); chk("of_t4_busy", b0.busy, 1);
        step();
        chk("of_idle_state", b0.tstate, 0); chk("of_idle_busy", b0.busy, 0); chk("of_idle_status", {b0.S1, b0.S0}, 0);

        // Memory write 0x8001 <- 0xA5
        issue(0, 3'd2, 16'h8001, 8'hA5);
        step(); b0.mc_start = 0;
        chk("mw_t1_status", {b0.S1, b0.S0}, 2'b01); chk("mw_t1_IOMn", b0.IOMn, 0);
        chk("mw_t1_ad_out", b0.ad_out, 8'h01); chk("mw_t1_haddr", b0.haddress, 8'h80);
        step();
        chk("mw_t2_WRn", b0.WRn, 0); chk("mw_t2_RDn", b0.RDn, 1); chk("mw_t2_ad_out", b0.ad_out, 8'hA5); chk("mw_t2_ad_oe", b0.ad_oe, 1);
        step();
        chk("mw_t3_state", b0.tstate, 4); chk("mw_t3_WRn", b0.WRn, 0); chk("mw_t3_ad_out", b0.ad_out, 8'hA5);
        step();
        chk("mw_end_state", b0.tstate, 0); chk("mw_end_WRn", b0.WRn, 1); chk("mw_end_busy", b0.busy, 0);

        // IO read of port 0x2F
        issue(0, 3'd3, 16'h002F, 8'h00); b0.ad_in = 8'h5A; q0.push_back(8'h5A);
        step(); b0.mc_start = 0;
        chk("ior_t1_IOMn", b0.IOMn, 1); chk("ior_t1_haddr", b0.haddress, 8'h2F);
        chk("ior_t1_ad_out", b0.ad_out, 8'h2F); chk("ior_t1_status", {b0.S1, b0.S0}, 2'b10);
        step(); step(); step();
        chk("ior_end_state", b0.tstate, 0); chk("ior_end_rdata", b0.rdata, 8'h5A);

        // Memory read with ready low for three wait states
        issue(0, 3'd1, 16'h4000, 8'h00); b0.ready = 0; b0.ad_in = 8'h77; q0.push_back(8'h77);
        step(); b0.mc_start = 0;
        step();
        chk("mrw_t2_RDn", b0.RDn, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrw_tw_state", b0.tstate, 3); chk("mrw_tw_RDn", b0.RDn, 0); chk("mrw_tw_err", b0.bus_err, 0);
        end
        b0.ready = 1;
        step();
        chk("mrw_t3_state", b0.tstate, 4); chk("mrw_t3_err", b0.bus_err, 0);
        step();
        chk("mrw_end_state", b0.tstate, 0);

        // Wait timeout with MAX_WAIT=2
        issue(1, 3'd1, 16'h0010, 8'h00); b1.ready = 0; b1.ad_in = 8'h99; q1.push_back(8'h99);
        step(); b1.mc_start = 0;
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("to_tw_state", b1.tstate, 3); chk("to_tw_err", b1.bus_err, 0);
        end
        step();
        chk("to_t3_state", b1.tstate, 4); chk("to_t3_err", b1.bus_err, 1);
        step();
        chk("to_end_state", b1.tstate, 0); chk("to_end_err", b1.bus_err, 0); chk("to_end_rdata", b1.rdata, 8'h99);
        b1.ready = 1;

        // Back-to-back: fetch, then mem read requested during T4
        issue(0, 3'd0, 16'h0100, 8'h00); b0.ad_in = 8'hC3; q0.push_back(8'hC3);
        step(); b0.mc_start = 0;
        step(); chk("b2b_t2_busy", b0.busy, 1);
        step(); chk("b2b_t3_busy", b0.busy, 1);
        step(); chk("b2b_t4_state", b0.tstate, 5); chk("b2b_t4_busy", b0.busy, 1);
        issue(0, 3'd1, 16'h0200, 8'h00); b0.ad_in = 8'h3C; q0.push_back(8'h3C);
        step(); b0.mc_start = 0;
        chk("b2b_t1_state", b0.tstate, 1); chk("b2b_t1_busy", b0.busy, 1); chk("b2b_t1_ALE", b0.ALE, 1);
        chk("b2b_t1_haddr", b0.haddress, 8'h02); chk("b2b_t1_status", {b0.S1, b0.S0}, 2'b10);
        step(); step(); step();
        chk("b2b_end_state", b0.tstate, 0); chk("b2b_end_rdata", b0.rdata, 8'h3C);

        // Reset asserted during T2 of a read
        issue(0, 3'd1, 16'h1111, 8'h00); b0.ad_in = 8'hEE;
        step(); b0.mc_start = 0;
        step();
        chk("rr_t2_RDn", b0.RDn, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_RDn", b0.RDn, 1); chk("rr_ALE", b0.ALE, 0); chk("rr_ad_oe", b0.ad_oe, 0);
        chk("rr_state", b0.tstate, 0); chk("rr_busy", b0.busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rr_idle", b0.tstate, 0);

        // Invalid type in IDLE is ignored
        issue(0, 3'd6, 16'hFFFF, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("inv_state", b0.tstate, 0); chk("inv_ALE", b0.ALE, 0); chk("inv_busy", b0.busy, 0); chk("inv_ad_oe", b0.ad_oe, 0);
        end
        b0.mc_start = 0;
        step(); step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
